// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared FSM state type, keymap table and column helper for keypad_scanner
//
// Purpose : common definitions for the 4x4 keypad scanner.
// Ports   : none (package).
//   state_t      - 2-bit FSM state encoding (SCAN, DEBOUNCE, HELD, RELEASE)
//   KEYMAP       - 16-entry key code table indexed by {row, column}
//   next_col()   - advances the one-hot active-low column drive by one position
package keypad_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_SCAN     = 2'd0;
   localparam state_t ST_DEBOUNCE = 2'd1;
   localparam state_t ST_HELD     = 2'd2;
   localparam state_t ST_RELEASE  = 2'd3;

   localparam logic [3:0] COL_RESET = 4'b1110;

   // Index is {row[1:0], col[1:0]}; the leftmost entry is index 15.
   //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: E(*) 0 F(#) D
   localparam logic [15:0][3:0] KEYMAP = {
      4'hD, 4'hF, 4'h0, 4'hE,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   // 1110 -> 1101 -> 1011 -> 0111 -> 1110
   function automatic logic [3:0] next_col(input logic [3:0] c);
      return {c[2:0], c[3]};
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - free-running prescaler producing the keypad scan tick
//
// Purpose : counts 0..SCAN_DIV-1 and wraps; tick is high for the single
//           cycle in which the count equals SCAN_DIV-1.
// Ports   :
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset, clears the count
//   tick  - one-cycle scan strobe
module scan_tick_gen #(
   parameter int SCAN_DIV = 100000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce, single-key (no rollover)
//
// Purpose : drives one column low at a time, watches the rows, debounces a
//           press and its release over DEBOUNCE scan ticks and reports the key.
// Ports   :
//   clk       - clock, rising edge
//   reset     - asynchronous active-low reset
//   row[3:0]  - keypad rows, active-low, pulled up; row[0] is the top row
//   col[3:0]  - column drive, one-hot active-low; col[0] is the leftmost column
//   key_code  - hex code of the last accepted key
//   key_valid - one-cycle pulse per accepted press
//   key_held  - high from press acceptance until release acceptance
//   is_digit  - key_code is 0..9, updated together with key_code
module keypad_scanner #(
   parameter int SCAN_DIV = 100000,
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic       is_digit
);

   import keypad_pkg::*;

   localparam int CNT_W = $clog2(DEBOUNCE + 1);
   // Count value whose increment completes the debounce window.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             tick;
   logic [3:0]       row_meta;
   logic [3:0]       row_sync;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       cap_row;
   logic [1:0]       cap_col;
   logic             press_pend;

   logic             any_low;
   logic [1:0]       low_idx;
   logic [1:0]       col_idx;
   logic             row_hit;

   scan_tick_gen #(
      .SCAN_DIV(SCAN_DIV)
   ) u_tick (
      .clk  (clk),
      .reset(reset),
      .tick (tick)
   );

   // Rows come straight from mechanical switches; resync before any use.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_meta <= 4'b1111;
         row_sync <= 4'b1111;
      end else begin
         row_meta <= row;
         row_sync <= row_meta;
      end
   end

   assign any_low = ~&row_sync;
   assign row_hit = ~row_sync[cap_row];

   // Lowest-index low row wins when several rows are pressed together.
   always_comb begin
      low_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!row_sync[i]) begin
            low_idx = i[1:0];
         end
      end
   end

   always_comb begin
      case (col)
         4'b1110: col_idx = 2'd0;
         4'b1101: col_idx = 2'd1;
         4'b1011: col_idx = 2'd2;
         4'b0111: col_idx = 2'd3;
         default: col_idx = 2'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_SCAN;
         col        <= COL_RESET;
         cnt        <= '0;
         cap_row    <= 2'd0;
         cap_col    <= 2'd0;
         press_pend <= 1'b0;
         key_code   <= 4'h0;
         key_valid  <= 1'b0;
         key_held   <= 1'b0;
         is_digit   <= 1'b0;
      end else begin
         key_valid  <= 1'b0;
         press_pend <= 1'b0;

         // Acceptance is reported one cycle after entering HELD.
         if (press_pend) begin
            key_code  <= KEYMAP[{cap_row, cap_col}];
            is_digit  <= (KEYMAP[{cap_row, cap_col}] <= 4'd9);
            key_valid <= 1'b1;
            key_held  <= 1'b1;
         end

         if (tick) begin
            case (state)
               ST_SCAN: begin
                  if (any_low) begin
                     cap_row <= low_idx;
                     cap_col <= col_idx;
                     cnt     <= CNT_ONE;
                     if (DEBOUNCE <= 1) begin
                        state      <= ST_HELD;
                        press_pend <= 1'b1;
                     end else begin
                        state <= ST_DEBOUNCE;
                     end
                  end else begin
                     col <= next_col(col);
                  end
               end

               ST_DEBOUNCE: begin
                  if (row_hit) begin
                     cnt <= cnt + 1'b1;
                     if (cnt == CNT_LAST) begin
                        state      <= ST_HELD;
                        press_pend <= 1'b1;
                     end
                  end else begin
                     // Bounce: abandon this key and keep scanning.
                     state <= ST_SCAN;
                     cnt   <= '0;
                     col   <= next_col(col);
                  end
               end

               ST_HELD: begin
                  if (!row_hit) begin
                     if (DEBOUNCE <= 1) begin
                        state    <= ST_SCAN;
                        cnt      <= '0;
                        key_held <= 1'b0;
                        col      <= next_col(col);
                     end else begin
                        state <= ST_RELEASE;
                        cnt   <= CNT_ONE;
                     end
                  end
               end

               ST_RELEASE: begin
                  if (!row_hit) begin
                     cnt <= cnt + 1'b1;
                     if (cnt == CNT_LAST) begin
                        state    <= ST_SCAN;
                        cnt      <= '0;
                        key_held <= 1'b0;
                        col      <= next_col(col);
                     end
                  end else begin
                     // Release bounce: still the same press, no new report.
                     state <= ST_HELD;
                     cnt   <= '0;
                  end
               end

               default: begin
                  state <= ST_SCAN;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000: clk cycles per scan tick (1 ms at 100 MHz).
REQ-002 SHALL have parameter DEBOUNCE, default 4: number of consecutive equal scan-tick samples needed to accept a press or a release.
REQ-003 SHALL have port clk, input, 1: the single clock; every register uses its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port row, input, 4: keypad rows, active-low, externally pulled up; row[0] is the top row.
REQ-006 SHALL have port col, output, 4: keypad column drive, one-hot active-low; col[0] is the leftmost column.
REQ-007 SHALL have port key_code, output, 4: code of the last accepted key.
REQ-008 SHALL have port key_valid, output, 1: one-cycle pulse when a press is accepted.
REQ-009 SHALL have port key_held, output, 1: high from press acceptance until release is accepted.
REQ-010 SHALL have port is_digit, output, 1: high when key_code <= 9, qualified with key_code.

Function
REQ-011 SHALL use keymap row0: 1 2 3 A; row1: 4 5 6 B; row2: 7 8 9 C; row3: E(*) 0 F(#) D. key_code is the hex value of the key.
REQ-012 SHALL pass row through a 2-flop synchronizer before any use.
REQ-013 SHALL run a prescaler counting 0..SCAN_DIV-1 that wraps to 0 and asserts an internal tick for one cycle at SCAN_DIV-1.
REQ-014 SHALL sample the synchronized rows and change state or column only on tick cycles.
REQ-015 SHALL implement a 4-state FSM with states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-016 SCAN: on a tick, if any row is low, SHALL capture the lowest-index low row and the current column, set the debounce count to 1 and go to DEBOUNCE; otherwise SHALL advance the column mod 4 (1110, 1101, 1011, 0111, 1110).
REQ-017 DEBOUNCE: SHALL freeze col; on a tick with the captured row low, SHALL increment the count. When the count reaches DEBOUNCE, SHALL go to HELD and, in the following cycle, load key_code and is_digit, pulse key_valid and set key_held.
REQ-018 DEBOUNCE: on a tick with the captured row high, SHALL return to SCAN, advance the column, and produce no key_valid.
REQ-019 HELD: SHALL keep col frozen; on a tick with the captured row high, SHALL go to RELEASE with the count at 1.
REQ-020 RELEASE: on a tick with the row high, SHALL increment the count. When the count reaches DEBOUNCE, SHALL clear key_held, go to SCAN and advance the column. On a tick with the row low, SHALL return to HELD with no new key_valid.
REQ-021 SHALL ignore other keys while in DEBOUNCE, HELD or RELEASE (no rollover).
REQ-022 SHALL give exactly one key_valid pulse per accepted press; key_code and is_digit SHALL hold until the next accepted press.
REQ-023 SHALL produce a minimum press-to-key_valid latency of DEBOUNCE ticks plus one clk cycle.

Reset
REQ-024 While reset is low, SHALL immediately force: state SCAN, col 4'b1110, prescaler 0, debounce count 0, synchronizer 4'b1111, key_code 0, key_valid 0, key_held 0, is_digit 0.
REQ-025 On reset during any state, a key still held after reset deasserts SHALL be detected again and reported exactly once after DEBOUNCE ticks.

Structure
REQ-026 Package keypad_pkg SHALL hold the FSM state type and the 16-entry keymap constant table.
REQ-027 The prescaler SHALL be a single sub-module, scan_tick_gen (inputs clk and reset, parameter SCAN_DIV, output tick).

Verification (SCAN_DIV=4, DEBOUNCE=3)
REQ-028 Idle rows 1111 -> col steps 1110, 1101, 1011, 0111, 1110 every 4 cycles; key_valid never asserts.
REQ-029 Key '5' (row1 low while col=1101) held for 10 ticks -> one key_valid pulse, key_code=5, is_digit=1; key_held high until 3 high ticks after release.
REQ-030 Bounce on '5': low 2 ticks, high 1 tick, then low steady -> no pulse until 3 consecutive low ticks, then exactly one pulse.
REQ-031 Key '#' (row3, col=1011) -> key_code=F, is_digit=0.
REQ-032 Rows 0 and 2 low together at col=1110 -> key_code=1; no second pulse while held.
REQ-033 reset low during HELD -> all outputs 0 immediately; with the key still held after reset releases -> exactly one key_valid, same code, after 3 ticks.
